// File: rtl/niosii_ram_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter.
// Default widths match the 1024x32 RAM.
package niosii_ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef logic       mst_id_t;
    typedef logic [7:0] hold_cnt_t;

    function automatic mst_id_t other_mst(input mst_id_t m);
        return ~m;
    endfunction

endpackage

// File: rtl/niosii_rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock hold.
// Grant is combinational; last winner and hold state are registered.
module niosii_rr_arb2
    import niosii_ram_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       accept,
    output logic [1:0] gnt,
    output mst_id_t    last_q
);

    localparam hold_cnt_t HOLD_LIM = hold_cnt_t'(MAX_HOLD);

    mst_id_t   last_d;
    mst_id_t   win;
    logic      hold_q, hold_d;
    logic      hold_eff;
    hold_cnt_t hold_cnt_q, hold_cnt_d;
    hold_cnt_t run;

    always_comb begin
        // The hold lapses as soon as the holder drops lock or its request.
        hold_eff = hold_q & req[last_q] & lock[last_q];
        win      = mst_id_t'(req[1]);
        if (hold_eff) begin
            win = last_q;
        end else if (req == 2'b11) begin
            win = other_mst(last_q);
        end
        gnt = 2'b00;
        if (accept) begin
            gnt = win ? 2'b10 : 2'b01;
        end
        run        = hold_eff ? hold_cnt_q + 8'd1 : 8'd1;
        last_d     = last_q;
        hold_d     = 1'b0;
        hold_cnt_d = '0;
        if (accept) begin
            last_d = win;
            if (lock[win] && run < HOLD_LIM) begin
                hold_d     = 1'b1;
                hold_cnt_d = run;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= 1'b1;
            hold_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/niosii_ram_arbiter.sv
// Shares the single-port on-chip RAM between the Nios II data master
// and the packet-filter engine; routes read returns to the issuer.
module niosii_ram_arbiter
    import niosii_ram_arb_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic                m0_lock,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic                m1_lock,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       any_req;
    logic       wr_sel;
    mst_id_t    last_q;
    mst_id_t    sel;
    logic       rsp_vld_q, rsp_vld_d;
    mst_id_t    rsp_id_q, rsp_id_d;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign any_req = (|req) & reset_n;

    niosii_rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .lock    ({m1_lock, m0_lock}),
        .accept  (any_req),
        .gnt     (gnt),
        .last_q  (last_q)
    );

    // With no request the port keeps pointing at the last winner.
    assign sel = any_req ? mst_id_t'(gnt[1]) : last_q;

    always_comb begin
        unique case (sel)
            1'b0: begin
                ram_address    = m0_address;
                ram_byteenable = m0_byteenable;
                ram_writedata  = m0_writedata;
                wr_sel         = m0_write;
            end
            default: begin
                ram_address    = m1_address;
                ram_byteenable = m1_byteenable;
                ram_writedata  = m1_writedata;
                wr_sel         = m1_write;
            end
        endcase
    end

    assign ram_chipselect = any_req;
    assign ram_write      = any_req & wr_sel;
    assign ram_clken      = 1'b1;

    assign m0_waitrequest = req[0] & ~gnt[0];
    assign m1_waitrequest = req[1] & ~gnt[1];

    assign rsp_vld_d = any_req & ~wr_sel;
    assign rsp_id_d  = any_req ? sel : rsp_id_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign m0_readdatavalid = rsp_vld_q & (rsp_id_q == 1'b0);
    assign m1_readdatavalid = rsp_vld_q & (rsp_id_q == 1'b1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_niosii_ram_arbiter.sv
// Directed and random checks of the RAM arbiter against a
// cycle-level reference model with a shadow copy of the RAM.
module tb_niosii_ram_arbiter;

    localparam int MAXH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rd, wr, lk;
    logic [9:0]  ad [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];

    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata, ram_readdata;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int          n_chk = 0;
    int          n_pass = 0;
    int          last_m, run_m, pend_id, dg;
    bit          pend_v;
    logic [31:0] pend_d, got_rd;

    always #5 clk = ~clk;

    niosii_ram_arbiter #(
        .ADDR_W   (10),
        .DATA_W   (32),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (ad[0]),
        .m0_byteenable    (be[0]),
        .m0_read          (rd[0]),
        .m0_write         (wr[0]),
        .m0_lock          (lk[0]),
        .m0_writedata     (wd[0]),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (ad[1]),
        .m1_byteenable    (be[1]),
        .m1_read          (rd[1]),
        .m1_write         (wr[1]),
        .m1_lock          (lk[1]),
        .m1_writedata     (wd[1]),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    function automatic logic [31:0] pre(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // On-chip RAM: byte-enabled, one-cycle read latency.
    initial begin
        for (int a = 0; a < 1024; a++) mem[a] <= pre(a);
    end

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b])
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle_all();
        rd = '0; wr = '0; lk = '0;
        for (int m = 0; m < 2; m++) begin
            ad[m] = '0; be[m] = '0; wd[m] = '0;
        end
    endtask

    // One clock cycle: inputs already applied just after the falling edge.
    task automatic step();
        int  w;
        bit  r0, r1;
        #1;
        r0 = rd[0] | wr[0];
        r1 = rd[1] | wr[1];
        if (!r0 && !r1)     w = -1;
        else if (!r1)       w = 0;
        else if (!r0)       w = 1;
        else if (run_m > 0 && lk[last_m]) w = last_m;
        else                w = 1 - last_m;
        chk("cs", 32'(ram_chipselect), 32'(w >= 0));
        chk("wait0", 32'(m0_waitrequest), 32'(r0 && w != 0));
        chk("wait1", 32'(m1_waitrequest), 32'(r1 && w != 1));
        if (w >= 0) begin
            chk("addr", 32'(ram_address), 32'(ad[w]));
            chk("rwr", 32'(ram_write), 32'(wr[w]));
            if (wr[w]) begin
                chk("be", 32'(ram_byteenable), 32'(be[w]));
                chk("wdata", ram_writedata, wd[w]);
            end
        end
        chk("rdv0", 32'(m0_readdatavalid), 32'(pend_v && pend_id == 0));
        chk("rdv1", 32'(m1_readdatavalid), 32'(pend_v && pend_id == 1));
        if (pend_v) begin
            got_rd = pend_id == 1 ? m1_readdata : m0_readdata;
            chk("rdata", got_rd, pend_d);
        end
        dg = (r0 && !m0_waitrequest) ? 0 :
             (r1 && !m1_waitrequest) ? 1 : -1;
        @(posedge clk);
        pend_v = 0;
        if (w >= 0) begin
            if (wr[w]) begin
                for (int b = 0; b < 4; b++)
                    if (be[w][b]) ref_mem[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
            end else begin
                pend_v  = 1;
                pend_id = w;
                pend_d  = ref_mem[ad[w]];
            end
            if (lk[w]) begin
                run_m = (w == last_m ? run_m : 0) + 1;
                if (run_m >= MAXH) run_m = 0;
            end else begin
                run_m = 0;
            end
            last_m = w;
        end else begin
            run_m = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_all();
        #1;
        chk("rst_cs", 32'(ram_chipselect), 32'd0);
        chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_m = 1; run_m = 0; pend_v = 0; dg = -1;
    endtask

    task automatic rand_req(input int m);
        int k;
        k = $urandom_range(0, 7);
        rd[m] = (k >= 2 && k <= 4) || k == 7;
        wr[m] = k >= 5;
        lk[m] = $urandom_range(0, 2) == 0;
        ad[m] = 10'($urandom_range(0, 15));
        be[m] = 4'($urandom);
        wd[m] = $urandom;
    endtask

    initial begin
        int exp_l [8] = '{0, 1, 1, 1, 1, 0, 1, 0};
        int n0, n1;
        for (int a = 0; a < 1024; a++) ref_mem[a] = pre(a);
        idle_all();
        @(negedge clk);
        do_reset();

        // Single read by m0.
        rd[0] = 1; ad[0] = 10'h005;
        step();
        idle_all();
        step();
        chk("t1_data", got_rd, pre(5));

        // Continuous writes, alternating grants starting with m0.
        do_reset();
        n0 = 0; n1 = 0;
        wr = 2'b11; be[0] = 4'hF; be[1] = 4'hF;
        for (int i = 0; i < 16; i++) begin
            ad[0] = 10'(10'h100 + n0); wd[0] = 32'hA0000000 + 32'(n0);
            ad[1] = 10'(10'h200 + n1); wd[1] = 32'hB0000000 + 32'(n1);
            step();
            chk("alt", 32'(dg), 32'(i % 2));
            if (dg == 0) n0++;
            if (dg == 1) n1++;
        end
        idle_all();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                rd[0] = 1;
                ad[0] = i < 8 ? 10'(10'h100 + i) : 10'(10'h200 + i - 8);
            end else begin
                rd[0] = 0;
            end
            step();
            if (i > 0)
                chk("alt_rb", got_rd, i - 1 < 8 ? 32'hA0000000 + 32'(i - 1)
                                                 : 32'hB0000000 + 32'(i - 9));
        end

        // m1 lock hold of MAX_HOLD grants against a busy m0.
        do_reset();
        n0 = 0; n1 = 0;
        wr = 2'b11; lk = 2'b10; be[0] = 4'hF; be[1] = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i >= 5) lk[1] = 0;
            ad[0] = 10'(10'h300 + n0); wd[0] = 32'h11110000 + 32'(n0);
            ad[1] = 10'(10'h340 + n1); wd[1] = 32'h22220000 + 32'(n1);
            step();
            chk("lock", 32'(dg), 32'(exp_l[i]));
            if (dg == 0) n0++;
            if (dg == 1) n1++;
        end

        // Partial byte write by m0, read back by m1 the next cycle.
        idle_all();
        wr[0] = 1; ad[0] = 10'h3FF; be[0] = 4'b0011; wd[0] = 32'hDEADBEEF;
        step();
        idle_all();
        rd[1] = 1; ad[1] = 10'h3FF;
        step();
        idle_all();
        step();
        chk("bytes", got_rd, 32'hC0DEBEEF);

        // Read and write together is a write.
        rd[0] = 1; wr[0] = 1; ad[0] = 10'h020; be[0] = 4'hF; wd[0] = 32'h12345678;
        step();
        idle_all();
        step();
        rd[0] = 1; ad[0] = 10'h020;
        step();
        idle_all();
        step();
        chk("rw_data", got_rd, 32'h12345678);

        // Reset while an m1 read response is pending.
        rd[1] = 1; ad[1] = 10'h007;
        step();
        do_reset();
        rd = 2'b11; ad[0] = 10'h001; ad[1] = 10'h002;
        step();
        chk("rst_tie", 32'(dg), 32'd0);
        idle_all();
        step();

        // Random traffic; a stalled master keeps its request unchanged.
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++)
                if (!((rd[m] | wr[m]) && dg != m)) rand_req(m);
            step();
        end
        idle_all();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
